bptt_seq_ctrl: RTL and testbench
================================

Name: bptt_seq_ctrl

Overview:
- Sequencer for the LSTM time-step history buffer and step datapath.
- Forward pass: issues NUM_ITERATIONS forward steps to the datapath. After each completed step it pulses the history shift-register enable, so the buffer holds one word per step.
- Backward (BPTT) pass: replays the steps newest-first, driving the history slot select.
- Sits between the top-level training FSM (start/done) and the LSTM step datapath plus history buffer.

Parameters:
- NUM_ITERATIONS, 68, number of time steps per sequence (≥2).
- IDXW, 7, width of step index; must satisfy 2^IDXW ≥ NUM_ITERATIONS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  request a full forward+backward run; sampled only in IDLE.
- abort  in  1  cancel run; returns to IDLE.
- busy  out  1  high from the cycle after start is accepted until the cycle after DONE.
- done  out  1  one-cycle pulse when the backward pass completes.
- mode  out  1  0 = forward, 1 = backward.
- dp_go  out  1  one-cycle pulse: datapath starts one step.
- dp_ack  in  1  datapath step complete; honoured only in WAIT states.
- hist_clr  out  1  one-cycle pulse: clear history buffer.
- shift_en  out  1  one-cycle pulse: shift current datapath output into the history buffer.
- t_idx  out  IDXW  current step index; in backward mode also the history slot select.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: state IDLE; busy, done, mode, dp_go, hist_clr, shift_en = 0; t_idx = 0.
- Outputs are Moore-decoded from registered state and counter; no combinational path from inputs to outputs.
- States: IDLE, CLR, FWD_GO, FWD_WAIT, SHIFT, BWD_GO, BWD_WAIT, DONE.
- IDLE: start=1 → CLR, t_idx←0, mode←0.
- CLR: hist_clr=1 → FWD_GO.
- FWD_GO: dp_go=1 → FWD_WAIT.
- FWD_WAIT: hold until dp_ack=1 → SHIFT.
- SHIFT: shift_en=1.
  - If t_idx==NUM_ITERATIONS-1: → BWD_GO, mode←1, t_idx holds NUM_ITERATIONS-1.
  - Else: t_idx←t_idx+1 → FWD_GO.
- BWD_GO: dp_go=1 → BWD_WAIT.
- BWD_WAIT: on dp_ack=1:
  - If t_idx==0: → DONE.
  - Else: t_idx←t_idx-1 → BWD_GO.
- DONE: done=1 → IDLE; mode←0, t_idx←0.
- busy is 1 in every state except IDLE.
- Buffer convention: after N shifts the newest word sits in slot N-1 and the oldest in slot 0. The backward pass therefore selects slots N-1 down to 0, equal to t_idx.
- Latency with dp_ack in the first WAIT cycle:
  - Forward step: 3 cycles. Backward step: 2 cycles.
  - Total from the start-sampled cycle to done: 1 + 3N + 2N + 1 cycles, i.e. done high at cycle 5N+2.
- Boundaries:
  - start while busy: ignored.
  - dp_ack in any non-WAIT state: ignored, not latched.
  - dp_ack held high: each WAIT entry consumes it once.
  - abort: from any state → IDLE next cycle; all pulses deasserted, t_idx←0, mode←0, no done. Abort beats start and dp_ack in the same cycle.
  - rst mid-run: identical to abort, plus all registers go to reset values.
  - No wrap: t_idx never exceeds NUM_ITERATIONS-1 and never underflows below 0.

Decomposition:
- Shared header lstm_ctrl_defs.vh holds:
  - state encodings (3-bit localparams);
  - MODE_FWD = 0, MODE_BWD = 1.
- One natural sub-module, step_counter:
  - IDXW-bit up/down counter with clr, inc, dec;
  - flags at_zero and at_last (==NUM_ITERATIONS-1).
- The FSM instantiates step_counter once.

Test Plan:
- N=4, start pulse at cycle 0, dp_ack one cycle after each dp_go:
  - hist_clr at cycle 1;
  - dp_go at cycles 2, 5, 8, 11 with shift_en at 4, 7, 10, 13 and t_idx 0..3;
  - mode=1 from cycle 14; dp_go at 14, 16, 18, 20 with t_idx 3, 2, 1, 0;
  - done at cycle 22; busy falls at cycle 23.
- dp_ack delayed 5 cycles on forward step 2:
  - FWD_WAIT holds;
  - no extra dp_go or shift_en;
  - total shift_en count = 4.
- Spurious dp_ack during FWD_GO, SHIFT and IDLE:
  - ignored; step count and pulse sequence unchanged.
- start re-asserted at cycles 3 and 15 during a run:
  - no effect; exactly one done.
- abort during backward step t_idx=2:
  - next cycle IDLE, busy=0, t_idx=0, mode=0, no done;
  - a new start runs a full clean sequence beginning with hist_clr.
- rst asserted at cycle 9 of a run:
  - all outputs 0 next cycle;
  - start asserted simultaneously with rst is ignored.

Source files
------------

// File: rtl/bptt_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bptt_seq_ctrl_pkg
// Shared definitions for the LSTM forward/BPTT step sequencer:
//   - seq_state_e : 3-bit sequencer state encoding
//   - MODE_FWD / MODE_BWD : values driven on the mode output
//   - is_wait_state() : true for the states in which dp_ack is honoured
// -----------------------------------------------------------------------------
package bptt_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLR      = 3'd1,
        ST_FWD_GO   = 3'd2,
        ST_FWD_WAIT = 3'd3,
        ST_SHIFT    = 3'd4,
        ST_BWD_GO   = 3'd5,
        ST_BWD_WAIT = 3'd6,
        ST_DONE     = 3'd7
    } seq_state_e;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_BWD = 1'b1;

    // dp_ack is only meaningful while a step is outstanding on the datapath.
    function automatic logic is_wait_state(input seq_state_e st);
        logic res;
        case (st)
            ST_FWD_WAIT: res = 1'b1;
            ST_BWD_WAIT: res = 1'b1;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bptt_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// bptt_seq_ctrl_if
// Bundles the control handshake between the training FSM / LSTM step datapath
// / history buffer (master side) and the sequencer (slave side).
//   start, abort  : run control from the training FSM
//   busy, done    : run status back to the training FSM
//   dp_go, dp_ack : per-step handshake with the datapath
//   mode          : 0 forward, 1 backward
//   hist_clr      : clear the history buffer
//   shift_en      : push the current datapath output into the history buffer
//   t_idx         : step index / history slot select
// -----------------------------------------------------------------------------
interface bptt_seq_ctrl_if #(
    parameter int IDXW = 7
);
    logic            start;
    logic            abort;
    logic            dp_ack;
    logic            busy;
    logic            done;
    logic            mode;
    logic            dp_go;
    logic            hist_clr;
    logic            shift_en;
    logic [IDXW-1:0] t_idx;

    modport master (
        output start, abort, dp_ack,
        input  busy, done, mode, dp_go, hist_clr, shift_en, t_idx
    );

    modport slave (
        input  start, abort, dp_ack,
        output busy, done, mode, dp_go, hist_clr, shift_en, t_idx
    );
endinterface

// File: rtl/bptt_seq_ctrl_step_counter.sv
// -----------------------------------------------------------------------------
// bptt_seq_ctrl_step_counter
// Saturating up/down step index counter for the sequencer.
//   clk, rst    : clock, synchronous active-high reset
//   clr_i       : force index to 0 (highest priority)
//   inc_i       : count up, holds at NUM_ITERATIONS-1
//   dec_i       : count down, holds at 0
//   idx_o       : registered step index
//   at_zero_o   : idx_o == 0
//   at_last_o   : idx_o == NUM_ITERATIONS-1
// -----------------------------------------------------------------------------
module bptt_seq_ctrl_step_counter #(
    parameter int NUM_ITERATIONS = 68,
    parameter int IDXW           = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [IDXW-1:0] idx_o,
    output logic            at_zero_o,
    output logic            at_last_o
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_ITERATIONS - 1);
    localparam logic [IDXW-1:0] ZERO_IDX = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);

    logic [IDXW-1:0] cnt_d;
    logic [IDXW-1:0] cnt_q;

    // Next index: clear wins, then increment, then decrement; never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = ZERO_IDX;
        end else if (inc_i && (cnt_q != LAST_IDX)) begin
            cnt_d = cnt_q + ONE_IDX;
        end else if (dec_i && (cnt_q != ZERO_IDX)) begin
            cnt_d = cnt_q - ONE_IDX;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= ZERO_IDX;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx_o     = cnt_q;
    assign at_zero_o = (cnt_q == ZERO_IDX);
    assign at_last_o = (cnt_q == LAST_IDX);

endmodule

// File: rtl/bptt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bptt_seq_ctrl
// Sequencer for the LSTM time-step history buffer and step datapath. A run
// clears the history buffer, issues NUM_ITERATIONS forward steps (shifting
// each result into the buffer), then replays the steps newest-first with
// t_idx selecting the history slot, and finally pulses done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bptt_seq_ctrl_if slave modport
//              in : start, abort, dp_ack
//              out: busy, done, mode, dp_go, hist_clr, shift_en, t_idx
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module bptt_seq_ctrl
    import bptt_seq_ctrl_pkg::*;
#(
    parameter int NUM_ITERATIONS = 68,
    parameter int IDXW           = 7
) (
    input  logic             clk,
    input  logic             rst,
    bptt_seq_ctrl_if.slave   bus
);

    seq_state_e state_q;
    logic       busy_q;
    logic       done_q;
    logic       mode_q;
    logic       dp_go_q;
    logic       hist_clr_q;
    logic       shift_en_q;

    logic            ack_valid_s;
    logic            cnt_clr_s;
    logic            cnt_inc_s;
    logic            cnt_dec_s;
    logic [IDXW-1:0] idx_s;
    logic            at_zero_s;
    logic            at_last_s;

    assign ack_valid_s = bus.dp_ack && is_wait_state(state_q);

    // Step counter control: the index is parked at 0 outside a run and moves
    // only at the end of a forward shift or a completed backward step.
    always_comb begin
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        cnt_dec_s = 1'b0;
        if (bus.abort) begin
            cnt_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:     cnt_clr_s = 1'b1;
                ST_SHIFT:    cnt_inc_s = !at_last_s;
                ST_BWD_WAIT: cnt_dec_s = ack_valid_s && !at_zero_s;
                ST_DONE:     cnt_clr_s = 1'b1;
                default:     cnt_clr_s = 1'b0;
            endcase
        end
    end

    bptt_seq_ctrl_step_counter #(
        .NUM_ITERATIONS (NUM_ITERATIONS),
        .IDXW           (IDXW)
    ) u_step_counter (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr_s),
        .inc_i     (cnt_inc_s),
        .dec_i     (cnt_dec_s),
        .idx_o     (idx_s),
        .at_zero_o (at_zero_s),
        .at_last_o (at_last_s)
    );

    // Sequencer FSM; each output register is loaded with the value that
    // belongs to the state being entered, so outputs track state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= MODE_FWD;
            dp_go_q    <= 1'b0;
            hist_clr_q <= 1'b0;
            shift_en_q <= 1'b0;
        end else if (bus.abort) begin
            // Abort overrides start and dp_ack and never produces done.
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= MODE_FWD;
            dp_go_q    <= 1'b0;
            hist_clr_q <= 1'b0;
            shift_en_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            dp_go_q    <= 1'b0;
            hist_clr_q <= 1'b0;
            shift_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_CLR;
                        busy_q     <= 1'b1;
                        hist_clr_q <= 1'b1;
                        mode_q     <= MODE_FWD;
                    end else begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                ST_CLR: begin
                    state_q <= ST_FWD_GO;
                    dp_go_q <= 1'b1;
                end
                ST_FWD_GO: begin
                    state_q <= ST_FWD_WAIT;
                end
                ST_FWD_WAIT: begin
                    if (ack_valid_s) begin
                        state_q    <= ST_SHIFT;
                        shift_en_q <= 1'b1;
                    end else begin
                        state_q    <= ST_FWD_WAIT;
                    end
                end
                ST_SHIFT: begin
                    // Last forward step: index stays on the newest slot,
                    // which is where the backward pass starts.
                    if (at_last_s) begin
                        state_q <= ST_BWD_GO;
                        mode_q  <= MODE_BWD;
                    end else begin
                        state_q <= ST_FWD_GO;
                    end
                    dp_go_q <= 1'b1;
                end
                ST_BWD_GO: begin
                    state_q <= ST_BWD_WAIT;
                end
                ST_BWD_WAIT: begin
                    if (ack_valid_s) begin
                        if (at_zero_s) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_BWD_GO;
                            dp_go_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_BWD_WAIT;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    mode_q  <= MODE_FWD;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    mode_q  <= MODE_FWD;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mode     = mode_q;
    assign bus.dp_go    = dp_go_q;
    assign bus.hist_clr = hist_clr_q;
    assign bus.shift_en = shift_en_q;
    assign bus.t_idx    = idx_s;

endmodule

// File: tb/tb_bptt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bptt_seq_ctrl
// Directed bench for bptt_seq_ctrl with NUM_ITERATIONS=4. Cycle 0 is the cycle
// in which start is sampled; outputs are sampled on the falling edge and
// compared against a hand-written timeline of the reference run.
// Trace vector layout: {busy, done, mode, dp_go, hist_clr, shift_en, t_idx[2:0]}
// -----------------------------------------------------------------------------
module tb_bptt_seq_ctrl;

    localparam int N = 4;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bptt_seq_ctrl_if #(.IDXW(W)) bus ();

    bptt_seq_ctrl #(
        .NUM_ITERATIONS (N),
        .IDXW           (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] trace [0:63];
    int cnt_go;
    int cnt_shift;
    int cnt_done;
    int cnt_clr;
    int done_cyc;

    function automatic logic [8:0] sample();
        return {bus.busy, bus.done, bus.mode, bus.dp_go, bus.hist_clr, bus.shift_en, bus.t_idx};
    endfunction

    // Hand-derived timeline of the reference run (dp_ack one cycle after dp_go).
    function automatic logic [8:0] base_exp(input int c);
        logic       busy_e, done_e, mode_e, go_e, clr_e, sh_e;
        logic [2:0] t_e;
        busy_e = (c >= 1) && (c <= 22);
        done_e = (c == 22);
        mode_e = (c >= 14) && (c <= 22);
        go_e   = (c == 2) || (c == 5) || (c == 8) || (c == 11) ||
                 (c == 14) || (c == 16) || (c == 18) || (c == 20);
        clr_e  = (c == 1);
        sh_e   = (c == 4) || (c == 7) || (c == 10) || (c == 13);
        if ((c >= 5) && (c <= 7))        t_e = 3'd1;
        else if ((c >= 8) && (c <= 10))  t_e = 3'd2;
        else if ((c >= 11) && (c <= 15)) t_e = 3'd3;
        else if ((c >= 16) && (c <= 17)) t_e = 3'd2;
        else if ((c >= 18) && (c <= 19)) t_e = 3'd1;
        else                             t_e = 3'd0;
        return {busy_e, done_e, mode_e, go_e, clr_e, sh_e, t_e};
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [8:0] obs, input logic [8:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One run: start in cycle 0, a datapath model that acks one cycle after
    // each dp_go (plus 'extra' on dp_go number delay_go), optional spurious
    // acks, start re-assertions, abort and rst at fixed cycles.
    task automatic run_seq(input int ncyc, input int delay_go, input int extra,
                           input logic [63:0] spur, input logic [63:0] start_m,
                           input int abort_cyc, input int rst_cyc);
        int         ack_at;
        int         go_idx;
        logic [8:0] s;
        ack_at    = -1;
        go_idx    = 0;
        cnt_go    = 0;
        cnt_shift = 0;
        cnt_done  = 0;
        cnt_clr   = 0;
        done_cyc  = -1;
        for (int i = 0; i < 64; i++) trace[i] = 9'd0;
        trace[0]   = sample();
        bus.start  = 1'b1;
        bus.dp_ack = spur[0];
        bus.abort  = (abort_cyc == 0);
        rst        = (rst_cyc == 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            s        = sample();
            trace[c] = s;
            if (s[5]) begin
                ack_at = c + 1 + ((go_idx == delay_go) ? extra : 0);
                go_idx++;
                cnt_go++;
            end
            if (s[3]) cnt_shift++;
            if (s[4]) cnt_clr++;
            if (s[7]) begin
                cnt_done++;
                done_cyc = c;
            end
            bus.start  = start_m[c];
            bus.dp_ack = (c == ack_at) || spur[c];
            bus.abort  = (c == abort_cyc);
            rst        = (rst_cyc == c);
        end
        bus.start  = 1'b0;
        bus.dp_ack = 1'b0;
        bus.abort  = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        logic [8:0] e;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.dp_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", 0, sample(), 9'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_reset", 0, sample(), 9'd0);

        // Reference run.
        run_seq(32, -1, 0, 64'd0, 64'd0, -1, -1);
        for (int c = 1; c <= 32; c++) chk("base", c, trace[c], base_exp(c));
        chk_int("base_go_count", cnt_go, 8);
        chk_int("base_shift_count", cnt_shift, 4);
        chk_int("base_clr_count", cnt_clr, 1);
        chk_int("base_done_count", cnt_done, 1);
        chk_int("base_done_cycle", done_cyc, 22);

        // Forward step 2 acked 5 cycles late: FWD_WAIT holds at t_idx=1.
        run_seq(36, 1, 5, 64'd0, 64'd0, -1, -1);
        for (int c = 1; c <= 36; c++) begin
            if (c <= 5)       e = base_exp(c);
            else if (c <= 11) e = {1'b1, 5'b00000, 3'd1};
            else              e = base_exp(c - 5);
            chk("delay", c, trace[c], e);
        end
        chk_int("delay_go_count", cnt_go, 8);
        chk_int("delay_shift_count", cnt_shift, 4);
        chk_int("delay_done_cycle", done_cyc, 27);

        // Spurious dp_ack in IDLE (0, 25), FWD_GO (2) and SHIFT (4, 7).
        run_seq(32, -1, 0, 64'h0000_0000_0200_0095, 64'd0, -1, -1);
        for (int c = 1; c <= 32; c++) chk("spurious", c, trace[c], base_exp(c));
        chk_int("spurious_shift_count", cnt_shift, 4);

        // dp_ack held high for the whole run: one consumption per WAIT entry.
        run_seq(32, -1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, -1, -1);
        for (int c = 1; c <= 32; c++) chk("ack_held", c, trace[c], base_exp(c));

        // start re-asserted at cycles 3 and 15 while busy.
        run_seq(32, -1, 0, 64'd0, 64'h0000_0000_0000_8008, -1, -1);
        for (int c = 1; c <= 32; c++) chk("restart", c, trace[c], base_exp(c));
        chk_int("restart_done_count", cnt_done, 1);

        // abort in BWD_WAIT at t_idx=2, same cycle as dp_ack.
        run_seq(32, -1, 0, 64'd0, 64'd0, 17, -1);
        for (int c = 1; c <= 32; c++) chk("abort", c, trace[c], (c <= 17) ? base_exp(c) : 9'd0);
        chk_int("abort_done_count", cnt_done, 0);

        // Fresh run after abort starts clean with hist_clr.
        run_seq(32, -1, 0, 64'd0, 64'd0, -1, -1);
        for (int c = 1; c <= 32; c++) chk("after_abort", c, trace[c], base_exp(c));
        chk_int("after_abort_done_count", cnt_done, 1);

        // abort and start together in IDLE: abort wins.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_beats_start", 0, sample(), 9'd0);

        // rst at cycle 9 together with start: everything returns to zero.
        run_seq(32, -1, 0, 64'd0, 64'h0000_0000_0000_0200, -1, 9);
        for (int c = 1; c <= 32; c++) chk("rst_mid", c, trace[c], (c <= 9) ? base_exp(c) : 9'd0);
        chk_int("rst_mid_done_count", cnt_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
